// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - state codes, opcodes and datapath control encodings
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_EXEC_I    = 4'd10,
        S_I_WB      = 4'd11,
        S_JAL       = 4'd12,
        S_INVALID   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_LUI
    } aluop_t;

    typedef enum logic [1:0] {PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP} pcsrc_t;
    typedef enum logic [1:0] {SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} srcb_t;
    typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA} regdst_t;
    typedef enum logic [1:0] {M2R_ALUOUT, M2R_MDR, M2R_PC} memtoreg_t;

    typedef struct packed {
        logic      pc_write;
        logic      pc_write_cond;
        logic      branch_ne;
        logic      i_or_d;
        logic      mem_read;
        logic      mem_write;
        logic      ir_write;
        logic      alu_src_a;
        logic      reg_write;
        pcsrc_t    pc_source;
        srcb_t     alu_src_b;
        regdst_t   reg_dst;
        memtoreg_t mem_to_reg;
        aluop_t    alu_op;
        logic      instr_done;
        logic      illegal_op;
    } ctrl_t;

    // Codes above the last defined state collapse onto one value that decodes to no outputs.
    function automatic state_t to_state(input logic [31:0] s);
        if (s > 32'd12)
            return S_INVALID;
        return state_t'(s[3:0]);
    endfunction

    function automatic logic is_imm_op(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_LUI: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic aluop_t imm_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller to datapath signal bundle
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNe;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               ALUSrcA;
    logic               RegWrite;
    logic [1:0]         PCSource;
    logic [1:0]         ALUSrcB;
    logic [1:0]         RegDst;
    logic [1:0]         MemtoReg;
    logic [2:0]         ALUOp;
    logic [STATE_W-1:0] state;
    logic               instr_done;
    logic               illegal_op;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, RegWrite, PCSource, ALUSrcB, RegDst, MemtoReg, ALUOp,
               state, instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               ALUSrcA, RegWrite, PCSource, ALUSrcB, RegDst, MemtoReg, ALUOp,
               state, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_out_decode.sv
// rtl/multicycle_out_decode.sv - combinational state/opcode to datapath control decode
module multicycle_out_decode
    import multicycle_control_pkg::*;
(
    input  state_t     cur,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (cur)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !(opcode == OP_RTYPE || opcode == OP_LW || opcode == OP_SW ||
                                    opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_J ||
                                    opcode == OP_JAL || is_imm_op(opcode));
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (opcode == OP_BNE);
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = imm_aluop(opcode);
            end
            S_I_WB: begin
                // ALU op stays asserted so the ALUOut path is stable during writeback
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.alu_op     = imm_aluop(opcode);
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle processor control FSM
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    state_t             cur;
    state_t             nxt;
    ctrl_t              dec;
    ctrl_t              ctrl;

    assign cur = to_state(32'(state_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= STATE_W'(S_FETCH);
        else
            state_q <= state_d;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:     nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      nxt = S_EXEC_R;
                    OP_LW, OP_SW:  nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_J:          nxt = S_JUMP;
                    OP_JAL:        nxt = S_JAL;
                    default:       nxt = is_imm_op(bus.opcode) ? S_EXEC_I : S_FETCH;
                endcase
            end
            S_MEM_ADDR:  nxt = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  nxt = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nxt = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    nxt = S_R_WB;
            S_EXEC_I:    nxt = S_I_WB;
            default:     nxt = S_FETCH;
        endcase
        state_d = STATE_W'(nxt);
    end

    multicycle_out_decode u_decode (
        .cur       (cur),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .ctrl      (dec)
    );

    // Reset gates the decode directly so FETCH's MemRead is not visible while rst_n is low.
    always_comb begin
        if (rst_n)
            ctrl = dec;
        else
            ctrl = '0;
    end

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.BranchNe    = ctrl.branch_ne;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.illegal_op  = ctrl.illegal_op;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - bench for multicycle_control
module tb_multicycle_control;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BNE = 6'b000101, BEQ = 6'b000100;
    localparam logic [5:0] ORI = 6'b001101, SLTIU = 6'b001011, LUI = 6'b001111, RT = 6'b000000;
    localparam logic [5:0] JMP = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [21:0] ctl;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t tbl[$];
    vec_t sb[$];
    int   row_id[$];

    multicycle_control_if #(.STATE_W(4)) bus ();

    multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,BranchNe,IorD,MemRead,MemWrite,IRWrite,ALUSrcA,RegWrite,
    //  PCSource,ALUSrcB,RegDst,MemtoReg,ALUOp,instr_done,illegal_op}
    function automatic logic [21:0] mk(input logic pcw, pcwc, bne, iord, mrd, mwr, irw, srca, rw,
                                       input logic [1:0] pcs, srcb, rdst, m2r,
                                       input logic [2:0] aop, input logic done, ill);
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, srca, rw, pcs, srcb, rdst, m2r, aop, done, ill};
    endfunction

    function automatic logic [21:0] e_fetch(input logic r);
        return mk(r,0,0,0,1,0,r,0,0, 2'b00,2'b01,2'b00,2'b00, 3'b000, 0,0);
    endfunction
    function automatic logic [21:0] e_decode(input logic ill);
        return mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00, 3'b000, 0,ill);
    endfunction
    function automatic logic [21:0] e_maddr();
        return mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b10,2'b00,2'b00, 3'b000, 0,0);
    endfunction
    function automatic logic [21:0] e_mread();
        return mk(0,0,0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0);
    endfunction
    function automatic logic [21:0] e_mwb();
        return mk(0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b000, 1,0);
    endfunction
    function automatic logic [21:0] e_mwrite(input logic r);
        return mk(0,0,0,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, r,0);
    endfunction
    function automatic logic [21:0] e_execr();
        return mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0,0);
    endfunction
    function automatic logic [21:0] e_rwb();
        return mk(0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 3'b000, 1,0);
    endfunction
    function automatic logic [21:0] e_execi(input logic [2:0] a);
        return mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b10,2'b00,2'b00, a, 0,0);
    endfunction
    function automatic logic [21:0] e_iwb(input logic [2:0] a);
        return mk(0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, a, 1,0);
    endfunction
    function automatic logic [21:0] e_branch(input logic ne);
        return mk(0,1,ne,0,0,0,0,1,0, 2'b01,2'b00,2'b00,2'b00, 3'b001, 1,0);
    endfunction
    function automatic logic [21:0] e_jump();
        return mk(1,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b000, 1,0);
    endfunction
    function automatic logic [21:0] e_jal();
        return mk(1,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b10,2'b10, 3'b000, 1,0);
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [21:0] ctl);
        vec_t v;
        v.rst_n = r; v.op = op; v.mr = mr; v.st = st; v.ctl = ctl;
        tbl.push_back(v);
    endtask

    function automatic logic [21:0] actual_ctl();
        return {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.PCSource, bus.ALUSrcB, bus.RegDst,
                bus.MemtoReg, bus.ALUOp, bus.instr_done, bus.illegal_op};
    endfunction

    // Checker: pops the expectation queued for this cycle and compares away from the clock edge.
    initial begin
        vec_t v;
        int   id;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                v  = sb.pop_front();
                id = row_id.pop_front();
                total++;
                if (bus.state !== v.st) begin
                    bad++;
                    $display("FAIL row%0d state got=%0d want=%0d", id, bus.state, v.st);
                end
                total++;
                if (actual_ctl() !== v.ctl) begin
                    bad++;
                    $display("FAIL row%0d ctl got=%b want=%b", id, actual_ctl(), v.ctl);
                end
            end
        end
    end

    initial begin
        int cycles;
        int dones;
        bit left;
        bit back;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.opcode    = LW;
        bus.mem_ready = 1'b0;

        add(0, LW, 0, 0, '0);
        // LW, memory always ready
        add(1, LW, 1, 0, e_fetch(1)); add(1, LW, 1, 1, e_decode(0)); add(1, LW, 1, 2, e_maddr());
        add(1, LW, 1, 3, e_mread());  add(1, LW, 1, 4, e_mwb());
        // SW with three wait cycles in MEM_WRITE
        add(1, SW, 1, 0, e_fetch(1)); add(1, SW, 0, 1, e_decode(0)); add(1, SW, 0, 2, e_maddr());
        add(1, SW, 0, 5, e_mwrite(0)); add(1, SW, 0, 5, e_mwrite(0)); add(1, SW, 0, 5, e_mwrite(0));
        add(1, SW, 1, 5, e_mwrite(1));
        // BNE after one FETCH wait cycle, then BEQ
        add(1, BNE, 0, 0, e_fetch(0)); add(1, BNE, 1, 0, e_fetch(1)); add(1, BNE, 1, 1, e_decode(0));
        add(1, BNE, 0, 8, e_branch(1));
        add(1, BEQ, 1, 0, e_fetch(1)); add(1, BEQ, 1, 1, e_decode(0)); add(1, BEQ, 1, 8, e_branch(0));
        // immediate ops
        add(1, ORI, 1, 0, e_fetch(1)); add(1, ORI, 1, 1, e_decode(0));
        add(1, ORI, 1, 10, e_execi(3'b100)); add(1, ORI, 1, 11, e_iwb(3'b100));
        add(1, SLTIU, 1, 0, e_fetch(1)); add(1, SLTIU, 1, 1, e_decode(0));
        add(1, SLTIU, 1, 10, e_execi(3'b110)); add(1, SLTIU, 1, 11, e_iwb(3'b110));
        add(1, LUI, 1, 0, e_fetch(1)); add(1, LUI, 1, 1, e_decode(0));
        add(1, LUI, 1, 10, e_execi(3'b111)); add(1, LUI, 1, 11, e_iwb(3'b111));
        // R-type, J, JAL
        add(1, RT, 1, 0, e_fetch(1)); add(1, RT, 1, 1, e_decode(0));
        add(1, RT, 1, 6, e_execr()); add(1, RT, 1, 7, e_rwb());
        add(1, JMP, 1, 0, e_fetch(1)); add(1, JMP, 1, 1, e_decode(0)); add(1, JMP, 1, 9, e_jump());
        add(1, JAL, 1, 0, e_fetch(1)); add(1, JAL, 1, 1, e_decode(0)); add(1, JAL, 1, 12, e_jal());
        // illegal opcode returns to FETCH
        add(1, BAD, 1, 0, e_fetch(1)); add(1, BAD, 1, 1, e_decode(1));
        // LW abandoned by reset while waiting in MEM_READ
        add(1, LW, 1, 0, e_fetch(1)); add(1, LW, 1, 1, e_decode(0)); add(1, LW, 1, 2, e_maddr());
        add(1, LW, 0, 3, e_mread());  add(0, LW, 0, 0, '0);
        add(1, LW, 0, 0, e_fetch(0)); add(1, LW, 0, 0, e_fetch(0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n         = tbl[i].rst_n;
            bus.opcode    = tbl[i].op;
            bus.mem_ready = tbl[i].mr;
            sb.push_back(tbl[i]);
            row_id.push_back(i);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end

        // Hand sequence: full LW from FETCH back to FETCH, counting completion pulses.
        @(posedge clk);
        #1;
        bus.opcode    = LW;
        bus.mem_ready = 1'b1;
        cycles = 0;
        dones  = 0;
        left   = 1'b0;
        back   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.instr_done) dones++;
            if (bus.state != 4'd0)
                left = 1'b1;
            else if (left) begin
                back = 1'b1;
                break;
            end
        end
        total++;
        if (!back) begin
            bad++;
            $display("FAIL lw_return got=%0d want=1", back);
        end
        total++;
        if (cycles != 6) begin
            bad++;
            $display("FAIL lw_cycles got=%0d want=6", cycles);
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL lw_done_count got=%0d want=1", dones);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter STATE_W, default 4, width of the state register and state output.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 opcode  in  6  instruction[31:26] from instruction register, valid from DECODE onward.
REQ-005 mem_ready  in  1  memory handshake; high = current access completes this cycle.
REQ-006 PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite  out  1 each  multicycle datapath controls.
REQ-007 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 RegDst  out  2  00 rt, 01 rd, 10 register 31.
REQ-010 MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
REQ-011 ALUOp  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt, 110 sltu, 111 lui.
REQ-012 state  out  STATE_W  current state code.
REQ-013 instr_done  out  1  one-cycle pulse on final state of each instruction.
REQ-014 illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-015 Moore FSM; all outputs decoded from state (plus opcode where listed); unlisted outputs 0.
REQ-016 State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, JAL=12; codes 13-15 go to FETCH next cycle.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000; IRWrite=PCWrite=mem_ready; stay in FETCH until mem_ready=1, then DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000; next by opcode: 000000->EXEC_R; 100011/101011->MEM_ADDR; 000100/000101->BRANCH; 000010->JUMP; 000011->JAL; 001000,001001,001100,001101,001010,001011,001111->EXEC_I; other->FETCH with illegal_op=1.
REQ-019 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; ->MEM_READ if opcode 100011, else MEM_WRITE.
REQ-020 MEM_READ: MemRead=1, IorD=1; hold until mem_ready=1, then MEM_WB.
REQ-021 MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01, instr_done=1; ->FETCH.
REQ-022 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready=1; completing cycle instr_done=1, ->FETCH.
REQ-023 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010; ->R_WB. R_WB: RegWrite=1, RegDst=01, MemtoReg=00, instr_done=1; ->FETCH.
REQ-024 EXEC_I: ALUSrcA=1, ALUSrcB=10; ALUOp by opcode: 001000/001001->000, 001100->011, 001101->100, 001010->101, 001011->110, 001111->111; ->I_WB. I_WB: RegWrite=1, RegDst=00, MemtoReg=00, ALUOp held, instr_done=1; ->FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, BranchNe=(opcode==000101), instr_done=1; ->FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10, instr_done=1; ->FETCH.
REQ-027 JAL: RegWrite=1, RegDst=10, MemtoReg=10, PCWrite=1, PCSource=10, instr_done=1; ->FETCH.
REQ-028 mem_ready ignored outside FETCH, MEM_READ, MEM_WRITE; no timeout on wait states.

Reset
REQ-029 rst_n low: state=FETCH immediately, all outputs forced 0 (including FETCH MemRead) while low.
REQ-030 Reset mid-instruction abandons it; no write enable asserts in the cycle after rst_n deasserts except FETCH outputs.

Structure
REQ-031 Shared package: state codes, opcode constants, ALUOp/PCSource/ALUSrcB/RegDst/MemtoReg encodings.
REQ-032 Sub-module: multicycle_out_decode (combinational state+opcode -> outputs); FSM register and next-state logic in top.

Verification
REQ-033 LW, mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1,MemtoReg=01 in state 4; instr_done once.
REQ-034 SW with mem_ready low 3 cycles in MEM_WRITE -> state 5 held 4 cycles, MemWrite=1 throughout, single instr_done.
REQ-035 BNE 000101 -> 0,1,8,0; BranchNe=1, PCWriteCond=1, ALUOp=001 in state 8.
REQ-036 ORI then SLTIU -> EXEC_I ALUOp 100 then 110; JAL -> RegDst=10, MemtoReg=10, PCWrite=1.
REQ-037 Opcode 111111 -> illegal_op pulse in DECODE, next state FETCH; rst_n low in MEM_READ -> state 0, outputs 0 same cycle.
